// File: rtl/serial_tx_pkg.sv
// Shared types for the serial pattern transmitter: FSM state encoding and counter sizing.
package serial_tx_pkg;

    localparam int TX_STATE_W = 3;

    typedef enum logic [TX_STATE_W-1:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        PAR   = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    // Counter width for a value range 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down counter that saturates at zero; used for the bit and gap counts.
module tx_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a word on start and shifts it out MSB-first with a frame qualifier.
// Optional even-parity bit after the data when PARITY_EN is defined.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             x_out,
    output logic             frame,
    output logic             busy,
    output logic             done,
    output tx_state_t        state_dbg
);

    // The GAP parameter shadows the package state name, so the state is aliased here.
    localparam tx_state_t ST_GAP = serial_tx_pkg::GAP;

    localparam int BW = cnt_w(WIDTH);
    localparam int GW = cnt_w(GAP + 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic             bit_load, bit_dec, bit_zero;
    logic             gap_load, gap_dec, gap_zero;
    logic             accept;

    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d  = state_q;
        bit_load = 1'b0;
        bit_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    bit_load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_zero) begin
`ifdef PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end else begin
                    bit_dec = 1'b1;
                end
            end
`ifdef PARITY_EN
            PAR: state_d = DONE;
`endif
            DONE: begin
                if (GAP > 0) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ST_GAP: begin
                if (gap_zero) state_d = IDLE;
                else          gap_dec = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)                  shreg_q <= data_in;
            else if (state_q == SHIFT)   shreg_q <= shreg_q << 1;
        end
    end

`ifdef PARITY_EN
    logic par_q;

    // Parity is taken from the captured word, not from the shifting register.
    always_ff @(posedge clk or posedge res) begin
        if (res)         par_q <= 1'b0;
        else if (accept) par_q <= ^data_in;
    end

    assign x_out = (state_q == SHIFT) ? shreg_q[WIDTH-1] :
                   (state_q == PAR)   ? par_q : 1'b0;
    assign frame = (state_q == SHIFT) || (state_q == PAR);
`else
    assign x_out = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    assign frame = (state_q == SHIFT);
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    tx_down_counter #(.W(BW)) u_bitcnt (
        .clk      (clk),
        .res      (res),
        .load     (bit_load),
        .load_val (BIT_LOAD),
        .dec      (bit_dec),
        .zero     (bit_zero)
    );

    tx_down_counter #(.W(GW)) u_gapcnt (
        .clk      (clk),
        .res      (res),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

endmodule
